// File: rtl/gcd_controller_pkg.sv
// Shared definitions for the GCD controller and anything that drives or observes it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gcd_controller_pkg;

    // Operand width of the sequenced datapath.
    localparam int GCD_WIDTH_DEFAULT    = 16;
    // Subtraction steps allowed before an operation is aborted.
    localparam int GCD_MAX_ITER_DEFAULT = 65535;
    // Width of the step counter; MAX_ITER must fit in it.
    localparam int GCD_ITER_W           = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        SETTLE  = 3'd3,
        COMPUTE = 3'd4,
        FINISH  = 3'd5
    } gcd_state_e;

endpackage

// File: rtl/gcd_controller_if.sv
// Control and status bundle between the GCD controller and its subtract/compare datapath.
// Latency: n/a (wires only).
// Backpressure: op_valid/op_ready handshake for operands; all other signals are unconditioned.
//
// master : controller side (drives enables, selects, status)
// slave  : datapath / requester side (drives start, operand and compare flags)
interface gcd_controller_if;
    import gcd_controller_pkg::*;

    logic                  start;
    logic                  op_valid;
    logic                  op_zero;
    logic                  op_ready;
    logic                  gt;
    logic                  lt;
    logic                  eq;
    logic                  ldA;
    logic                  ldB;
    logic                  sel1;
    logic                  sel2;
    logic                  sel_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [GCD_ITER_W-1:0] iter_cnt;

    modport master (
        input  start, op_valid, op_zero, gt, lt, eq,
        output op_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_cnt
    );

    modport slave (
        output start, op_valid, op_zero, gt, lt, eq,
        input  op_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_cnt
    );

endinterface

// File: rtl/gcd_controller.sv
// Sequences a subtract-and-compare datapath to compute GCD(A, B) by repeated subtraction.
// Latency: start to done = load handshakes (2 min) + 1 settle + N steps + 1 eq + 1 finish.
// Backpressure: waits in LOAD_A/LOAD_B until op_valid; start is ignored while busy.
//
// Ports: clk, rst (synchronous, active-high); bus (gcd_controller_if.master) carries
//   start, operand handshake (op_valid/op_zero/op_ready), compare flags (gt/lt/eq),
//   datapath controls (ldA/ldB/sel1/sel2/sel_in) and status (busy/done/err/iter_cnt).
module gcd_controller
    import gcd_controller_pkg::*;
#(
    parameter int WIDTH    = GCD_WIDTH_DEFAULT,
    parameter int MAX_ITER = GCD_MAX_ITER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    gcd_controller_if.master  bus
);

    // The controller never touches operand data, but the width and step limit
    // still have to be sane for the datapath and the counter they pair with.
    if (WIDTH < 1) begin : g_width_check
        $error("gcd_controller: WIDTH must be at least 1");
    end
    if (MAX_ITER < 0 || MAX_ITER > (2 ** GCD_ITER_W) - 1) begin : g_iter_check
        $error("gcd_controller: MAX_ITER does not fit in iter_cnt");
    end

    localparam logic [GCD_ITER_W-1:0] ITER_LIMIT = GCD_ITER_W'(MAX_ITER);

    gcd_state_e            state;
    logic                  zero_flag;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [GCD_ITER_W-1:0] iter_q;

    // Step budget exhausted; the counter never moves past this value.
    logic at_limit;
    assign at_limit = (iter_q == ITER_LIMIT);

    // ------------------------------------------------------------------
    // State machine and registered status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            zero_flag <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            iter_q    <= '0;
        end else begin
            // done/err are single-cycle and only ever raised on entry to FINISH.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    // iter_cnt keeps the last result visible until a new start.
                    if (bus.start) begin
                        state     <= LOAD_A;
                        busy_q    <= 1'b1;
                        iter_q    <= '0;
                        zero_flag <= 1'b0;
                    end
                end

                LOAD_A: begin
                    if (bus.op_valid) begin
                        zero_flag <= zero_flag | bus.op_zero;
                        state     <= LOAD_B;
                    end
                end

                LOAD_B: begin
                    if (bus.op_valid) begin
                        zero_flag <= zero_flag | bus.op_zero;
                        state     <= SETTLE;
                    end
                end

                // Compare flags only reflect B one cycle after ldB.
                SETTLE: begin
                    state <= COMPUTE;
                end

                COMPUTE: begin
                    if (zero_flag) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (bus.eq) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                    end else if (at_limit) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        // Counts even when no flag is asserted, so a datapath
                        // that reports nothing still ends in a timeout.
                        iter_q <= iter_q + 1'b1;
                    end
                end

                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath control decode (combinational on state and inputs)
    // ------------------------------------------------------------------
    always_comb begin
        bus.op_ready = 1'b0;
        bus.ldA      = 1'b0;
        bus.ldB      = 1'b0;
        bus.sel1     = 1'b0;
        bus.sel2     = 1'b0;
        bus.sel_in   = 1'b0;

        // No loads while reset is held, so datapath contents survive reset.
        if (!rst) begin
            case (state)
                LOAD_A: begin
                    if (bus.op_valid) begin
                        bus.op_ready = 1'b1;
                        bus.ldA      = 1'b1;
                        bus.sel_in   = 1'b1;
                    end
                end

                LOAD_B: begin
                    if (bus.op_valid) begin
                        bus.op_ready = 1'b1;
                        bus.ldB      = 1'b1;
                        bus.sel_in   = 1'b1;
                    end
                end

                COMPUTE: begin
                    // Same priority as the state update: any terminating
                    // condition suppresses the subtraction.
                    if (!zero_flag && !bus.eq && !at_limit) begin
                        if (bus.gt) begin
                            bus.ldA  = 1'b1;   // A <= A - B
                            bus.sel2 = 1'b1;
                        end else if (bus.lt) begin
                            bus.ldB  = 1'b1;   // B <= B - A
                            bus.sel1 = 1'b1;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.iter_cnt = iter_q;

endmodule
